mem_arbiter: RTL and testbench

- Arbitrates the single shared RAM port between the instruction cache and the data cache.
- Drives RAM address, data and enables for one requester at a time.
- Returns per-requester wait/load signals.
- Data side has fixed priority; a starvation counter guarantees the instruction side forward progress.
- Grants are held across consecutive words so dcache block fills, writebacks and flushes stay contiguous.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and RAM-port signals of the shared
// RAM arbiter, bundled so the arbiter and its environment see one port.
// master: the arbiter's view (takes cache requests and RAM status, drives
//         the RAM port and the per-cache wait/load returns).
// slave:  the environment's view (caches and RAM model).
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          iwait;
    logic          dwait;
    logic [DW-1:0] iload;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and the dcache.
// The data side has fixed priority; a starvation counter forces a grant
// to the instruction side after STARVE_MAX waiting cycles. A grant is held
// across consecutive words so block fills and writebacks stay contiguous,
// and an in-flight word is never aborted.
// Optional build macro MEM_ARB_STATS_EN adds word-completion counters
// (icount, dcount) and a saturating starvation-preemption counter (preempt).
module mem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]  icount,
    output logic [31:0]  dcount,
    output logic [15:0]  preempt
`endif
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [SCW-1:0] scnt;
    logic           dreq;
    logic           starve;
    logic           access;
    logic           ren_c;
    logic           wen_c;
    logic [AW-1:0]  addr_c;
    logic [DW-1:0]  store_c;
    logic           iwait_c;
    logic           dwait_c;

    // Priority order: starving icache, then dcache, then icache.
    function automatic state_t arb(input logic s, input logic d, input logic i);
        if (s)      return IGRANT;
        else if (d) return DGRANT;
        else if (i) return IGRANT;
        else        return IDLE;
    endfunction

    assign dreq   = bus.dREN | bus.dWEN;
    assign starve = (scnt == SCW'(STARVE_MAX)) & bus.iREN;
    assign access = (bus.ramstate == RAM_ACCESS);

    // Read data is shared; the wait signals tell each cache when it is valid.
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;

    // Grant state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Starvation counter: cycles the icache has waited without a grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                             scnt <= '0;
        else if (!bus.iREN || state == IGRANT) scnt <= '0;
        else if (scnt != SCW'(STARVE_MAX))     scnt <= scnt + SCW'(1);
    end

    // RAM port mux, wait generation and re-arbitration at word boundaries.
    always_comb begin
        next_state = state;
        ren_c      = 1'b0;
        wen_c      = 1'b0;
        addr_c     = '0;
        store_c    = '0;
        iwait_c    = 1'b1;
        dwait_c    = 1'b1;
        unique case (state)
            IDLE: begin
                next_state = arb(starve, dreq, bus.iREN);
            end
            DGRANT: begin
                addr_c  = bus.daddr;
                store_c = bus.dstore;
                // A write wins if the dcache raises both enables.
                if (bus.dWEN) wen_c = 1'b1;
                else          ren_c = bus.dREN;
                dwait_c = ~access;
                if (!dreq)       next_state = arb(starve, 1'b0, bus.iREN);
                else if (access) next_state = arb(starve, 1'b1, bus.iREN);
            end
            IGRANT: begin
                addr_c  = bus.iaddr;
                ren_c   = bus.iREN;
                iwait_c = ~access;
                // starve needs iREN, so it cannot be set when iREN has dropped.
                if (!bus.iREN)   next_state = arb(1'b0, dreq, 1'b0);
                else if (access) next_state = arb(starve, dreq, 1'b1);
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    logic i_done;
    logic d_done;
    logic forced;

    assign i_done = (state == IGRANT) & access;
    assign d_done = (state == DGRANT) & access;
    // Forced entry: the icache wins only because it is starving while the
    // data side is still requesting.
    assign forced = (state != IGRANT) & (next_state == IGRANT) & starve & dreq;

    // Completion and preemption statistics.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount  <= '0;
            dcount  <= '0;
            preempt <= '0;
        end else begin
            if (i_done) icount <= icount + 32'd1;
            if (d_done) dcount <= dcount + 32'd1;
            if (forced && preempt != 16'hFFFF) preempt <= preempt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter. A stimulus process
// drives the caches and a RAM model, computes the expected port values from
// an owner/priority model and queues them; a monitor process pops and
// compares on every falling clock edge.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 8;

    localparam logic [1:0] R_FREE = 2'd0;
    localparam logic [1:0] R_BUSY = 2'd1;
    localparam logic [1:0] R_ACC  = 2'd2;
    localparam logic [1:0] R_ERR  = 2'd3;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
    logic [15:0] preempt;
`endif

    mem_arbiter #(.STARVE_MAX(SM), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .icount  (icount),
        .dcount  (dcount),
        .preempt (preempt)
`endif
    );

    typedef struct {
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] store;
        logic          iw;
        logic          dw;
        logic [DW-1:0] load;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } done_t;

    exp_t  exp_q[$];
    done_t idone_q[$];
    done_t ddone_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: who owns the RAM port and how long the icache waited.
    int owner      = OWN_NONE;
    int scnt       = 0;
    int lat_cnt    = 0;
    int lat_target = 2;
    bit i_act      = 1'b0;
    bit d_act      = 1'b0;
    int d_kind     = 0;   // 0 read, 1 write, 2 read+write
`ifdef MEM_ARB_STATS_EN
    int m_icnt = 0;
    int m_dcnt = 0;
    int m_pre  = 0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit s, input bit d, input bit i);
        if (s) return OWN_I;
        if (d) return OWN_D;
        if (i) return OWN_I;
        return OWN_NONE;
    endfunction

    // One clock cycle of cache behaviour, RAM behaviour and expectation.
    task automatic step(input int mode, input bit rst);
        exp_t  e;
        done_t dn;
        bit    dreq_v, starve_v, en, acc, own_req, holding;
        int    nxt, tmp;

        if (!i_act && (mode == 0 || $urandom_range(0, 99) < 40)) begin
            i_act     = 1'b1;
            bus.iaddr = $urandom;
        end
        if (!d_act && (mode == 0 || $urandom_range(0, 99) < 45)) begin
            d_act      = 1'b1;
            d_kind     = (mode == 0) ? 0 : int'($urandom_range(0, 2));
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
        end
        bus.iREN    = i_act;
        bus.dREN    = d_act && (d_kind != 1);
        bus.dWEN    = d_act && (d_kind != 0);
        bus.ramload = $urandom;

        dreq_v   = bus.dREN || bus.dWEN;
        starve_v = (scnt == SM) && bus.iREN;

        e.ren = 1'b0; e.wen = 1'b0; e.addr = '0; e.store = '0;
        e.iw = 1'b1; e.dw = 1'b1; e.load = bus.ramload;
        if (!rst && owner == OWN_D) begin
            e.addr  = bus.daddr;
            e.store = bus.dstore;
            e.wen   = bus.dWEN;
            e.ren   = bus.dREN && !bus.dWEN;
        end else if (!rst && owner == OWN_I) begin
            e.addr = bus.iaddr;
            e.ren  = bus.iREN;
        end

        en = e.ren || e.wen;
        if (en && lat_cnt >= lat_target) bus.ramstate = R_ACC;
        else if (en)                     bus.ramstate = $urandom_range(0, 1) ? R_BUSY : R_ERR;
        else begin
            tmp = $urandom_range(0, 2);
            bus.ramstate = (tmp == 0) ? R_FREE : (tmp == 1) ? R_BUSY : R_ERR;
        end
        if (en) lat_cnt++;
        acc = (bus.ramstate == R_ACC);

        if (acc) begin
            lat_cnt    = 0;
            lat_target = (mode == 0) ? 2 : int'($urandom_range(0, 3));
            if (owner == OWN_I) begin
                e.iw = 1'b0;
                dn.addr = bus.iaddr; dn.data = bus.ramload;
                idone_q.push_back(dn);
                i_act = 1'b0;
`ifdef MEM_ARB_STATS_EN
                m_icnt++;
`endif
            end else begin
                e.dw = 1'b0;
                dn.addr = bus.daddr; dn.data = bus.ramload;
                ddone_q.push_back(dn);
                d_act = 1'b0;
`ifdef MEM_ARB_STATS_EN
                m_dcnt++;
`endif
            end
        end
        exp_q.push_back(e);

        if (rst) begin
            owner   = OWN_NONE;
            scnt    = 0;
            lat_cnt = 0;
`ifdef MEM_ARB_STATS_EN
            m_icnt = 0; m_dcnt = 0; m_pre = 0;
`endif
        end else begin
            // The owner keeps the port while its word is in flight; otherwise
            // everyone still requesting (owner included) competes again.
            own_req = (owner == OWN_I) ? bus.iREN : (owner == OWN_D) ? dreq_v : 1'b0;
            holding = (owner != OWN_NONE) && own_req && !acc;
            nxt     = holding ? owner : pick(starve_v, dreq_v, bus.iREN);
`ifdef MEM_ARB_STATS_EN
            if (!holding && owner != OWN_I && nxt == OWN_I && starve_v && dreq_v && m_pre < 65535)
                m_pre++;
`endif
            if (!bus.iREN || owner == OWN_I) scnt = 0;
            else if (scnt < SM)              scnt = scnt + 1;
            owner = nxt;
        end
    endtask

    // Monitor: compare the DUT against the queued expectations mid-cycle.
    always @(negedge CLK) begin
        exp_t  e;
        done_t dn;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ramREN",   64'(bus.ramREN),   64'(e.ren));
            chk("ramWEN",   64'(bus.ramWEN),   64'(e.wen));
            chk("ramaddr",  64'(bus.ramaddr),  64'(e.addr));
            chk("ramstore", 64'(bus.ramstore), 64'(e.store));
            chk("iwait",    64'(bus.iwait),    64'(e.iw));
            chk("dwait",    64'(bus.dwait),    64'(e.dw));
            chk("iload",    64'(bus.iload),    64'(e.load));
            chk("dload",    64'(bus.dload),    64'(e.load));
            if (bus.iwait === 1'b0) begin
                if (idone_q.size() == 0) chk("i_unexpected_done", 64'(1), 64'(0));
                else begin
                    dn = idone_q.pop_front();
                    chk("i_done_addr", 64'(bus.ramaddr), 64'(dn.addr));
                    chk("i_done_data", 64'(bus.iload),   64'(dn.data));
                end
            end
            if (bus.dwait === 1'b0) begin
                if (ddone_q.size() == 0) chk("d_unexpected_done", 64'(1), 64'(0));
                else begin
                    dn = ddone_q.pop_front();
                    chk("d_done_addr", 64'(bus.ramaddr), 64'(dn.addr));
                    chk("d_done_data", 64'(bus.dload),   64'(dn.data));
                end
            end
        end
    end

    // Stimulus: reset, continuous contention, then random traffic with one
    // reset pulse landing in the middle of a dcache word.
    initial begin
        int  rst_phase;
        bit  rst_done;
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = R_FREE;
        rst_phase = 0;
        rst_done  = 1'b0;

        repeat (3) begin
            @(posedge CLK); #1;
            step(1, 1'b1);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        step(0, 1'b0);

        // Both caches request continuously with 3-cycle words: exercises
        // grant holding and the starvation hand-over.
        repeat (80) begin
            @(posedge CLK); #1;
            step(0, 1'b0);
        end

        for (int i = 0; i < 2500; i++) begin
            @(posedge CLK); #1;
            if (rst_phase == 1) begin
                step(1, 1'b1);
                rst_phase = 2;
            end else if (rst_phase == 2) begin
                nRST = 1'b1;
                step(1, 1'b0);
                rst_phase = 0;
            end else if (!rst_done && i >= 600 && owner == OWN_D && d_act && lat_cnt < lat_target) begin
                chk("pre_rst_enable", 64'(bus.ramREN | bus.ramWEN), 64'(1));
                nRST = 1'b0;
                #1;
                chk("rst_ramREN",  64'(bus.ramREN),  64'(0));
                chk("rst_ramWEN",  64'(bus.ramWEN),  64'(0));
                chk("rst_iwait",   64'(bus.iwait),   64'(1));
                chk("rst_dwait",   64'(bus.dwait),   64'(1));
                chk("rst_ramaddr", 64'(bus.ramaddr), 64'(0));
                step(1, 1'b1);
                rst_phase = 1;
                rst_done  = 1'b1;
            end else begin
                step(1, 1'b0);
            end
        end

        @(posedge CLK); #1;
        chk("reset_pulse_seen", 64'(rst_done), 64'(1));
        chk("exp_q_left",   64'(exp_q.size()),   64'(0));
        chk("idone_q_left", 64'(idone_q.size()), 64'(0));
        chk("ddone_q_left", 64'(ddone_q.size()), 64'(0));
`ifdef MEM_ARB_STATS_EN
        chk("icount",  64'(icount),  64'(m_icnt));
        chk("dcount",  64'(dcount),  64'(m_dcnt));
        chk("preempt", 64'(preempt), 64'(m_pre));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
